ula_arbiter: RTL

- Shares one 3-bit ALU (team module `ula`) between two requesters.
- Operations are arbitrated round-robin and passed through a req/gnt/done handshake.
- Operands are captured into registers, the ALU is evaluated, and result, carry/borrow and divide-by-zero flags are registered.
- Sits between two sequencing masters and the single ALU resource.

---
 rtl/ula_pkg.sv | 25 ++
 rtl/ula_arbiter_if.sv | 27 ++
 rtl/ula.sv | 42 ++++
 rtl/ula_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the arbitrated 3-bit ALU: opcodes, FSM states, defaults.
package ula_pkg;

    localparam int WIDTH_DEF = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_NEG = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ula_arbiter_if.sv
// Request/grant/done bundle between the two sequencing masters and the ALU arbiter.
interface ula_arbiter_if #(
    parameter int WIDTH = 3
);
    logic [1:0]       req;
    logic [2:0]       op0;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             dz;

    modport master (
        output req, op0, op1, a0, b0, a1, b1,
        input  gnt, done, result, cout, dz
    );

    modport slave (
        input  req, op0, op1, a0, b0, a1, b1,
        output gnt, done, result, cout, dz
    );
endinterface

// File: rtl/ula.sv
// Combinational ALU; carry/borrow taken from one extra bit of zero-extended arithmetic.
module ula
    import ula_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             c_o
);

    logic [WIDTH:0]   a_x;
    logic [WIDTH:0]   b_x;
    logic [WIDTH:0]   r_x;
    logic [WIDTH-1:0] neg_w;

    assign a_x   = {1'b0, a_i};
    assign b_x   = {1'b0, b_i};
    assign neg_w = ~a_i + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        r_x = '0;
        case (op_i)
            OP_ADD:  r_x = a_x + b_x;
            // MSB of the zero-extended difference is set exactly when a < b
            OP_SUB:  r_x = a_x - b_x;
            OP_AND:  r_x = {1'b0, a_i & b_i};
            OP_OR:   r_x = {1'b0, a_i | b_i};
            OP_XOR:  r_x = {1'b0, a_i ^ b_i};
            OP_NOT:  r_x = {1'b0, ~a_i};
            OP_NEG:  r_x = {1'b0, neg_w};
            OP_DIV:  r_x = (b_i != '0) ? {1'b0, a_i / b_i} : '0;
            default: r_x = '0;
        endcase
    end

    assign y_o = r_x[WIDTH-1:0];
    assign c_o = r_x[WIDTH];

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ula between two requesters via req/gnt/done.
//   state | meaning
//   IDLE  | waiting for any req; selected requester's op/a/b latched on exit
//   EXEC  | gnt[sel] high; ula evaluated, result/cout/dz registered on exit
//   RESP  | done[sel] high; served requester loses priority on exit
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int               WIDTH      = WIDTH_DEF,
    parameter int               PRIO_RESET = 0,
    parameter logic [WIDTH-1:0] DIV0_VAL   = {WIDTH{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    ula_arbiter_if.slave bus
);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             sel_q, sel_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;

    ula #(.WIDTH(WIDTH)) u_ula (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y),
        .c_o  (alu_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'(PRIO_RESET);
            sel_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    sel_d   = bus.req[ptr_q] ? ptr_q : ~ptr_q;
                    op_d    = sel_d ? bus.op1 : bus.op0;
                    a_d     = sel_d ? bus.a1  : bus.a0;
                    b_d     = sel_d ? bus.b1  : bus.b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_y;
                cout_d  = alu_c;
                dz_d    = 1'b0;
                // Unknown opcodes fail this compare and keep ula's zero result
                if ((op_q == OP_DIV) && (b_q == '0)) begin
                    res_d  = DIV0_VAL;
                    cout_d = 1'b0;
                    dz_d   = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = ~sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt    = (state_q == EXEC) ? onehot2(sel_q) : 2'b00;
    assign bus.done   = (state_q == RESP) ? onehot2(sel_q) : 2'b00;
    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.dz     = dz_q;

endmodule
